seq_shift_add_multiplier: RTL and testbench

//  Parametrised, multi-cycle shift-add multiplier for signed or unsigned operands.

---
 rtl/seq_mul_pkg.sv | 10 +
 rtl/cond_negate.sv | 12 +
 rtl/seq_shift_add_multiplier.sv | 116 +++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM state encodings and default width.
package seq_mul_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: out = neg ? 0 - in : in.
module cond_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    assign out = neg ? ({W{1'b0}} - in) : in;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-add multiplier for signed or unsigned operands, one multiplier bit per clock.
// Optional build macro SEQ_MUL_EARLY_TERM_EN stops stepping once no multiplier bits remain.
module seq_shift_add_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy
);

    // Handshakes: a request transfers on a rising edge where start && in_ready; a result
    // transfers on a rising edge where result_valid && result_ready. Once raised,
    // result_valid and result stay unchanged until that transfer happens.

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;
    logic               sign;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] signed_acc;
    logic               last_step;

    cond_negate #(.W(WIDTH)) u_mag_a (
        .neg (signed_mode & a[WIDTH-1]),
        .in  (a),
        .out (mag_a)
    );

    cond_negate #(.W(WIDTH)) u_mag_b (
        .neg (signed_mode & b[WIDTH-1]),
        .in  (b),
        .out (mag_b)
    );

    // The sign fix-up reads the settled acc register in DONE, keeping it off the adder path.
    cond_negate #(.W(2*WIDTH)) u_fixup (
        .neg (sign),
        .in  (acc),
        .out (signed_acc)
    );

`ifdef SEQ_MUL_EARLY_TERM_EN
    assign last_step = (count == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_step = (count == CNT_W'(WIDTH - 1));
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            count        <= '0;
            sign         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (last_step) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the product; later cycles wait for the consumer.
                    if (!result_valid) begin
                        result       <= signed_acc;
                        result_valid <= 1'b1;
                    end else if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier (WIDTH=32); latency expectations follow SEQ_MUL_EARLY_TERM_EN.
module tb_seq_shift_add_multiplier;

    localparam int W = 32;
`ifdef SEQ_MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           start;
    logic           in_ready;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] result;
    logic           result_valid;
    logic           result_ready;
    logic           busy;

    int compared   = 0;
    int mismatched = 0;

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_ready     (in_ready),
        .signed_mode  (signed_mode),
        .a            (a),
        .b            (b),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one request and wait (bounded) for result_valid; checks product and latency.
    task automatic run_op(input string tag, input logic sm, input logic [W-1:0] op_a,
                          input logic [W-1:0] op_b, input logic [63:0] exp_res,
                          input int lat_fixed, input int lat_early);
        int cyc;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        start       = 1'b1;
        signed_mode = sm;
        a           = op_a;
        b           = op_b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '1;
        b     = '1;
        cyc   = 0;
        while (!result_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(EARLY ? lat_early : lat_fixed));
        check({tag, "_result"}, result, exp_res);
    endtask

    // With result_ready high, the edge after valid returns to IDLE; result must be retained.
    task automatic finish_op(input string tag, input logic [63:0] exp_res);
        @(posedge clk);
        #1;
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_valid_clear"}, 64'(result_valid), 64'd0);
        check({tag, "_result_held"}, result, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        signed_mode  = 1'b0;
        a            = '0;
        b            = '0;
        result_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Signed and unsigned products
        run_op("s7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 33, 3);
        finish_op("s7xm3", 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, 33);
        finish_op("s_min_sq", 64'h4000_0000_0000_0000);
        run_op("u_max_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 33);
        finish_op("u_max_sq", 64'hFFFF_FFFE_0000_0001);
        run_op("sm5xm6", 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'd30, 33, 4);
        finish_op("sm5xm6", 64'd30);
        run_op("u0xb", 1'b0, 32'd0, 32'h1234_5678, 64'd0, 33, 30);
        finish_op("u0xb", 64'd0);
        run_op("u_msb_x2", 1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 33, 3);
        finish_op("u_msb_x2", 64'h0000_0001_0000_0000);
        run_op("u_msb_as_unsigned", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 33, 2);
        finish_op("u_msb_as_unsigned", 64'h0000_0000_FFFF_FFFF);

        // Back-pressure: result held, start ignored while in DONE
        result_ready = 1'b0;
        run_op("hold", 1'b0, 32'd3, 32'd4, 64'd12, 33, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 4);
            a     = 32'd100;
            b     = 32'd100;
            @(posedge clk);
            #1;
            if (i == 0 || i == 4 || i == 9) begin
                check("hold_result", result, 64'd12);
                check("hold_valid", 64'(result_valid), 64'd1);
                check("hold_in_ready", 64'(in_ready), 64'd0);
            end
        end
        @(negedge clk);
        start        = 1'b0;
        result_ready = 1'b1;
        finish_op("hold", 64'd12);
        repeat (3) @(posedge clk);
        #1;
        check("hold_start_ignored", 64'(busy), 64'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        start       = 1'b1;
        signed_mode = 1'b0;
        a           = 32'd7;
        b           = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_valid", 64'(result_valid), 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        run_op("u5x6", 1'b0, 32'd5, 32'd6, 64'd30, 33, 4);
        finish_op("u5x6", 64'd30);

        // Early-termination boundary: |b| == 1
        run_op("sm4x1", 1'b1, 32'hFFFF_FFFC, 32'd1, 64'hFFFF_FFFF_FFFF_FFFC, 33, 2);
        finish_op("sm4x1", 64'hFFFF_FFFF_FFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
